// File: rtl/pump_controller_pkg.sv
// +-------------------------------------------------------------------------+
// | pump_controller_pkg : level/state encodings, defaults, raw flag decode   |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
`default_nettype none

package pump_controller_pkg;

   localparam logic [2:0] LVL_EMPTY   = 3'd0;
   localparam logic [2:0] LVL_MID     = 3'd1;
   localparam logic [2:0] LVL_HALF    = 3'd2;
   localparam logic [2:0] LVL_FULL    = 3'd3;
   localparam logic [2:0] LVL_ILLEGAL = 3'd4;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_FILL  = 2'd1,
      ST_COOL  = 2'd2,
      ST_FAULT = 2'd3
   } state_e;

   localparam int DEF_DEBOUNCE     = 4;
   localparam int DEF_MIN_OFF      = 16;
   localparam int DEF_FILL_TIMEOUT = 64;
   localparam int DEF_CNT_W        = 16;

   // Empty asserted together with half or full cannot happen on a healthy sensor.
   function automatic logic [2:0] decode_level(input logic full, input logic half,
                                               input logic empty);
      logic [2:0] code;
      case ({full, half, empty})
         3'b001:         code = LVL_EMPTY;
         3'b000:         code = LVL_MID;
         3'b010:         code = LVL_HALF;
         3'b100, 3'b110: code = LVL_FULL;
         default:        code = LVL_ILLEGAL;
      endcase
      return code;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pump_controller_level_debounce.sv
// +-------------------------------------------------------------------------+
// | pump_controller_level_debounce : qualifies raw level flags by stability  |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
`default_nettype none

module pump_controller_level_debounce
   import pump_controller_pkg::*;
#(
   parameter int DEBOUNCE = DEF_DEBOUNCE,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       full_i,
   input  logic       half_i,
   input  logic       empty_i,
   output logic [2:0] level_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] THRESH  = CNT_W'(DEBOUNCE - 1);

   logic [2:0]       raw_d;
   logic [2:0]       raw_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       level_q;

   // cnt_d holds (identical consecutive samples - 1) including the one taken this edge.
   always_comb begin
      raw_d = decode_level(full_i, half_i, empty_i);
      cnt_d = cnt_q;
      if (raw_d != raw_q) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         raw_q   <= LVL_MID;
         cnt_q   <= '0;
         level_q <= LVL_MID;
      end else begin
         raw_q <= raw_d;
         cnt_q <= cnt_d;
         if (cnt_d >= THRESH) begin
            level_q <= raw_d;
         end
      end
   end

   assign level_o = level_q;

endmodule

`default_nettype wire

// File: rtl/pump_controller.sv
// +-------------------------------------------------------------------------+
// | pump_controller : debounced level flags driving a fill/cool pump FSM     |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
`default_nettype none

module pump_controller
   import pump_controller_pkg::*;
#(
   parameter int DEBOUNCE     = DEF_DEBOUNCE,
   parameter int MIN_OFF      = DEF_MIN_OFF,
   parameter int FILL_TIMEOUT = DEF_FILL_TIMEOUT,
   parameter int CNT_W        = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       full,
   input  logic       half,
   input  logic       empty,
   input  logic       en,
   input  logic       clr_fault,
   output logic       pump_on,
   output logic       alarm,
   output logic [1:0] state,
   output logic [2:0] level
);

   localparam logic [CNT_W-1:0] TIMER_MAX = '1;
   localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(MIN_OFF - 1);

   logic [2:0]       level_w;
   state_e           state_q;
   logic [CNT_W-1:0] timer_q;
   logic             half_seen_q;
   logic             pump_on_q;
   logic             alarm_q;

   pump_controller_level_debounce #(
      .DEBOUNCE (DEBOUNCE),
      .CNT_W    (CNT_W)
   ) u_level_debounce (
      .clk     (clk),
      .rst     (rst),
      .full_i  (full),
      .half_i  (half),
      .empty_i (empty),
      .level_o (level_w)
   );

   // Outputs are registered alongside the state so they always match state_q.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_OFF;
         timer_q     <= '0;
         half_seen_q <= 1'b0;
         pump_on_q   <= 1'b0;
         alarm_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_OFF: begin
               if (level_w == LVL_EMPTY && en) begin
                  state_q     <= ST_FILL;
                  timer_q     <= '0;
                  half_seen_q <= 1'b0;
                  pump_on_q   <= 1'b1;
               end
            end
            ST_FILL: begin
               if (timer_q != TIMER_MAX) begin
                  timer_q <= timer_q + CNT_W'(1);
               end
               if (level_w == LVL_HALF || level_w == LVL_FULL) begin
                  half_seen_q <= 1'b1;
               end
               if (level_w == LVL_ILLEGAL) begin
                  state_q   <= ST_FAULT;
                  pump_on_q <= 1'b0;
                  alarm_q   <= 1'b1;
               end else if (level_w == LVL_FULL || !en) begin
                  state_q   <= ST_COOL;
                  timer_q   <= '0;
                  pump_on_q <= 1'b0;
               end else if (timer_q == FILL_LAST && !half_seen_q) begin
                  state_q   <= ST_FAULT;
                  pump_on_q <= 1'b0;
                  alarm_q   <= 1'b1;
               end
            end
            ST_COOL: begin
               if (level_w == LVL_ILLEGAL) begin
                  state_q <= ST_FAULT;
                  alarm_q <= 1'b1;
               end else if (timer_q == COOL_LAST) begin
                  state_q <= ST_OFF;
               end else begin
                  timer_q <= timer_q + CNT_W'(1);
               end
            end
            ST_FAULT: begin
               // Recovery goes through COOL so the minimum off time still applies.
               if (clr_fault && level_w != LVL_ILLEGAL) begin
                  state_q <= ST_COOL;
                  timer_q <= '0;
                  alarm_q <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_OFF;
            end
         endcase
      end
   end

   assign pump_on = pump_on_q;
   assign alarm   = alarm_q;
   assign state   = state_q;
   assign level   = level_w;

endmodule

`default_nettype wire
